// File: rtl/lut_cell_sync.sv
// lut_cell_sync -- parameterised K-input fabric logic cell, single clock.
//
// Configuration arrives serially on the system clock. Bits are qualified by
// cfg_valid_i. Once a full frame has been received it is committed to the
// active config in one step. Bits that arrive after that pass through to the
// next cell on cfg_bit_o.
//
// Optional feature macro: LUT_CELL_CARRY_EN
//   When defined, the cell gains carry_i/carry_o and a carry_mode config bit.
//
// Frame order, first bit sent first:
//   reg_en, reg_init, [carry_mode], LUT[2^K-1] .. LUT[0]
//
// Ports:
//   clk_i, rst_n_i  system clock, async active-low reset
//   in_i[K]         LUT address
//   ce_i, sr_i      user register enable / sync reload to reg_init
//   cfg_valid_i     config shift strobe
//   cfg_bit_i       config serial data
//   cfg_clear_i     sync clear of frame, counter and active config
//   cfg_valid_o     cfg_valid_i forwarded combinationally to the next cell
//   cfg_bit_o       registered serial output (MSB of the frame register)
//   cfg_done_o      active config committed
//   out_o           cell output
//   carry_i/o       carry chain (LUT_CELL_CARRY_EN only)
module lut_cell_sync #(
   parameter int K = 4
) (
   input  logic         clk_i,
   input  logic         rst_n_i,
   input  logic [K-1:0] in_i,
   input  logic         ce_i,
   input  logic         sr_i,
   input  logic         cfg_valid_i,
   input  logic         cfg_bit_i,
   input  logic         cfg_clear_i,
`ifdef LUT_CELL_CARRY_EN
   input  logic         carry_i,
   output logic         carry_o,
`endif
   output logic         cfg_valid_o,
   output logic         cfg_bit_o,
   output logic         cfg_done_o,
   output logic         out_o
);

   localparam int LUT_N    = 1 << K;
`ifdef LUT_CELL_CARRY_EN
   localparam int CFG_BITS = LUT_N + 3;
`else
   localparam int CFG_BITS = LUT_N + 2;
`endif
   localparam int CW       = $clog2(CFG_BITS + 1);

   if (K < 2 || K > 6) begin : g_bad_k
      $error("lut_cell_sync: K must be in 2..6");
   end

   logic [CFG_BITS-1:0] shift;
   logic [CFG_BITS-1:0] shift_nxt;
   logic [CW-1:0]       cnt;
   logic [LUT_N-1:0]    lut_act;
   logic                reg_en;
   logic                reg_init;
   logic                q;
   logic                done;
   logic                commit;
   logic                p;
   logic                lut;

   assign shift_nxt = {shift[CFG_BITS-2:0], cfg_bit_i};
   // cnt saturates at CFG_BITS, so "full" doubles as the committed flag.
   assign done      = (cnt == CW'(CFG_BITS));
   assign commit    = cfg_valid_i && !cfg_clear_i && (cnt == CW'(CFG_BITS - 1));

   // Frame register and bit counter
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         shift <= '0;
         cnt   <= '0;
      end else if (cfg_clear_i) begin
         shift <= '0;
         cnt   <= '0;
      end else if (cfg_valid_i) begin
         shift <= shift_nxt;
         if (!done) cnt <= cnt + CW'(1);
      end
   end

   // Active config. It is loaded from shift_nxt so that the commit edge
   // already sees the final bit.
`ifdef LUT_CELL_CARRY_EN
   logic carry_mode;
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i)         carry_mode <= 1'b0;
      else if (cfg_clear_i) carry_mode <= 1'b0;
      else if (commit)      carry_mode <= shift_nxt[CFG_BITS-3];
   end
`endif

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         lut_act  <= '0;
         reg_en   <= 1'b0;
         reg_init <= 1'b0;
      end else if (cfg_clear_i) begin
         lut_act  <= '0;
         reg_en   <= 1'b0;
         reg_init <= 1'b0;
      end else if (commit) begin
         lut_act  <= shift_nxt[LUT_N-1:0];
         reg_en   <= shift_nxt[CFG_BITS-1];
         reg_init <= shift_nxt[CFG_BITS-2];
      end
   end

   // LUT read, optionally folded with the carry chain
   assign p = lut_act[in_i];
`ifdef LUT_CELL_CARRY_EN
   assign lut     = carry_mode ? (p ^ carry_i) : p;
   assign carry_o = done && carry_mode && (p ? carry_i : in_i[0]);
`else
   assign lut = p;
`endif

   // User register. A commit preloads it with the new reg_init value.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i)         q <= 1'b0;
      else if (cfg_clear_i) q <= 1'b0;
      else if (commit)      q <= shift_nxt[CFG_BITS-2];
      else if (sr_i)        q <= reg_init;
      else if (ce_i)        q <= lut;
   end

   assign cfg_valid_o = cfg_valid_i;
   assign cfg_bit_o   = shift[CFG_BITS-1];
   assign cfg_done_o  = done;
   assign out_o       = done && (reg_en ? q : lut);

endmodule

// File: tb/tb_lut_cell_sync.sv
// Self-checking bench for lut_cell_sync (K=2), directed scenarios plus
// randomized traffic compared against a frame-history reference model.
module tb_lut_cell_sync;
   localparam int K  = 2;
   localparam int LN = 4;
`ifdef LUT_CELL_CARRY_EN
   localparam int CB = LN + 3;
`else
   localparam int CB = LN + 2;
`endif

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [K-1:0] in_v = '0;
   logic         ce = 1'b0, sr = 1'b0, cv = 1'b0, cb = 1'b0, cclr = 1'b0;
   logic         cvo, cbo, done_o, out_v;
`ifdef LUT_CELL_CARRY_EN
   logic         carry_in = 1'b0;
   logic         carry_out;
`endif

   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   lut_cell_sync #(.K(K)) dut (
      .clk_i(clk), .rst_n_i(rst_n), .in_i(in_v), .ce_i(ce), .sr_i(sr),
      .cfg_valid_i(cv), .cfg_bit_i(cb), .cfg_clear_i(cclr),
`ifdef LUT_CELL_CARRY_EN
      .carry_i(carry_in), .carry_o(carry_out),
`endif
      .cfg_valid_o(cvo), .cfg_bit_o(cbo), .cfg_done_o(done_o), .out_o(out_v)
   );

   // Reference model: the last CB bits received since clear/reset, plus the
   // config captured from the first complete frame.
   bit          hist[$];
   bit          m_done, m_en, m_init, m_cm, m_q;
   bit [LN-1:0] m_lut;

   function automatic bit m_p();
      return m_lut[in_v];
   endfunction

   function automatic bit m_lutv();
`ifdef LUT_CELL_CARRY_EN
      return m_cm ? (m_p() ^ carry_in) : m_p();
`else
      return m_p();
`endif
   endfunction

   function automatic bit m_out();
      return m_done && (m_en ? m_q : m_lutv());
   endfunction

   function automatic bit m_cbo();
      return (hist.size() == CB) ? hist[0] : 1'b0;
   endfunction

   task automatic m_clear();
      hist.delete();
      m_done = 0; m_en = 0; m_init = 0; m_cm = 0; m_q = 0; m_lut = '0;
   endtask

   task automatic m_step();
      bit l, com;
      l   = m_lutv();
      com = 0;
      if (cclr) m_clear();
      else begin
         if (cv) begin
            hist.push_back(cb);
            if (hist.size() > CB) void'(hist.pop_front());
            if (!m_done && hist.size() == CB) begin
               com    = 1;
               m_done = 1;
               m_en   = hist[0];
               m_init = hist[1];
`ifdef LUT_CELL_CARRY_EN
               m_cm   = hist[2];
`endif
               for (int j = 0; j < LN; j++) m_lut[LN-1-j] = hist[CB-LN+j];
            end
         end
         if (com)     m_q = m_init;
         else if (sr) m_q = m_init;
         else if (ce) m_q = l;
      end
   endtask

   task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic check_all();
      chk("out", out_v, m_out());
      chk("done", done_o, m_done);
      chk("cfg_bit", cbo, m_cbo());
      chk("cfg_vo", cvo, cv);
`ifdef LUT_CELL_CARRY_EN
      chk("carry", carry_out, m_done && m_cm && (m_p() ? carry_in : in_v[0]));
`endif
   endtask

   // Called at posedge+1: check mid-cycle, take the edge, update the model.
   task automatic tick();
      #3 check_all();
      @(posedge clk);
      m_step();
      #1;
   endtask

   task automatic send(input bit b, input int gap);
      cv = 1; cb = b; tick();
      cv = 0;
      repeat (gap) tick();
   endtask

   task automatic send_frame(input bit en, input bit init, input bit cm,
                             input bit [LN-1:0] l, input int gap);
      send(en, gap);
      send(init, gap);
`ifdef LUT_CELL_CARRY_EN
      send(cm, gap);
`endif
      for (int i = LN - 1; i >= 0; i--) send(l[i], gap);
   endtask

   task automatic clear_pulse();
      cclr = 1; tick(); cclr = 0;
   endtask

   task automatic do_reset();
      rst_n = 0;
      #1;
      m_clear();
      chk("rst_out", out_v, 1'b0);
      chk("rst_done", done_o, 1'b0);
      chk("rst_cbit", cbo, 1'b0);
      @(posedge clk);
      #1 rst_n = 1;
   endtask

   initial begin
      #1;
      m_clear();
      chk("rst_out", out_v, 1'b0);
      chk("rst_done", done_o, 1'b0);
      chk("rst_cbit", cbo, 1'b0);
      #5 rst_n = 1;   // t=6, between edges

      // XOR load with gaps between strobes
      send_frame(0, 0, 0, 4'b0110, 2);
      chk("xor_done", done_o, 1'b1);
      for (int i = 0; i < 4; i++) begin
         in_v = K'(i);
         #1 chk("xor", out_v, in_v[0] ^ in_v[1]);
         tick();
      end

      // Pass-through: the old frame leaves on cfg_bit_o, function unchanged
      for (int i = 0; i < CB; i++) send(1, 0);
      for (int i = 0; i < 4; i++) begin
         in_v = K'(i);
         #1 chk("xor_pt", out_v, in_v[0] ^ in_v[1]);
         tick();
      end

      // Registered AND, init 1
      clear_pulse();
      send_frame(1, 1, 0, 4'b1000, 0);
      chk("reg_init", out_v, 1'b1);
      in_v = 2'b00; ce = 1; tick();
      chk("reg_ce", out_v, 1'b0);
      in_v = 2'b11; ce = 0; tick();
      chk("reg_hold", out_v, 1'b0);
      sr = 1; tick(); sr = 0;
      chk("reg_sr", out_v, 1'b1);

      // Mid-load abort, clear wins over a simultaneous strobe
      clear_pulse();
      for (int i = 0; i < 3; i++) send(1, 0);
      cclr = 1; cv = 1; cb = 1; tick(); cclr = 0; cv = 0;
      chk("abort_cnt", 8'(dut.cnt), 8'd0);
      send_frame(0, 0, 0, 4'b0110, 0);
      chk("abort_done", done_o, 1'b1);

      // Reset mid-load discards the partial frame
      clear_pulse();
      for (int i = 0; i < 4; i++) send(1, 0);
      do_reset();
      send_frame(0, 1, 0, 4'b0110, 1);
      chk("rld_done", done_o, 1'b1);

`ifdef LUT_CELL_CARRY_EN
      clear_pulse();
      send_frame(0, 0, 1, 4'b0110, 0);
      in_v = 2'b01; carry_in = 1;
      #1 chk("cy_out01", out_v, 1'b0);
      chk("cy_co01", carry_out, 1'b1);
      tick();
      in_v = 2'b11; carry_in = 0;
      #1 chk("cy_out11", out_v, 1'b0);
      chk("cy_co11", carry_out, 1'b1);
      tick();
`endif

      // Randomized traffic
      for (int n = 0; n < 4000; n++) begin
         if ($urandom_range(0, 599) == 0) do_reset();
         cv   = $urandom_range(0, 1);
         cb   = $urandom_range(0, 1);
         cclr = ($urandom_range(0, 79) == 0);
         ce   = $urandom_range(0, 1);
         sr   = ($urandom_range(0, 7) == 0);
         in_v = K'($urandom_range(0, 3));
`ifdef LUT_CELL_CARRY_EN
         carry_in = $urandom_range(0, 1);
`endif
         tick();
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
